instr_fetch: RTL and testbench
==============================

# instr_fetch

- Instruction-fetch stage of the pipelined RV32I core.
- Holds the program counter and drives the instruction-memory address.
- Captures the fetched word into the IF/ID pipeline register.
- Applies the PC redirect (PcSel/BrPC) produced by the EX-stage branch unit.
- Enters a sticky fault state on an illegal redirect target.

## Interface
Parameters:
- PC_W, 9, width of the PC and instruction-memory byte address
- INS_W, 32, instruction width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  hazard-unit hold (load-use); freezes PC and IF/ID
- pc_sel  in  1  redirect request from branch unit (1 = branch/jump taken)
- br_pc  in  32  redirect target byte address from branch unit
- imem_addr  out  PC_W  byte address to instruction ROM (combinational ROM, data same cycle)
- imem_rdata  in  INS_W  instruction word at imem_addr
- ifid_pc  out  PC_W  PC of instruction held in IF/ID
- ifid_instr  out  INS_W  instruction held in IF/ID
- ifid_valid  out  1  IF/ID holds a real instruction (0 = bubble)
- fault  out  1  sticky: illegal redirect target seen
- fetch_cnt  out  32  number of valid instructions loaded into IF/ID

## Operation
FSM, two states:
- RUN: reset state.
- HALT: entered from RUN when pc_sel=1 and the target is illegal.
  - Illegal target: br_pc[1:0]!=0 (misaligned), or br_pc[31:PC_W]!=0 (outside ROM).
  - Left only by reset.

PC register, RUN state (priority high to low):
- pc_sel=1, legal target: PC <= br_pc[PC_W-1:0].
- stall=1: PC holds.
- Otherwise: PC <= PC+4, modulo 2^PC_W (wraps from 2^PC_W-4 to 0).
- Redirect wins over stall.

PC register, HALT state: PC holds.

IF/ID register, RUN state:
- pc_sel=1: flush. Load ifid_instr=NOP (32'h00000013), ifid_valid=0, ifid_pc=current PC. Flush wins over stall.
- Else stall=1: hold all IF/ID fields.
- Else: load ifid_pc=PC, ifid_instr=imem_rdata, ifid_valid=1.

IF/ID register, HALT state: same as flush every cycle (bubbles).

Outputs:
- imem_addr = PC (combinational from the register).
- fetch_cnt increments by 1 on each cycle that loads ifid_valid=1. Wraps at 2^32.
- fault = (state==HALT), registered.
- The illegal redirect cycle itself flushes IF/ID. Its target is never loaded into the PC.

Reset values:
- PC=0, state=RUN, ifid_pc=0, ifid_instr=NOP, ifid_valid=0, fault=0, fetch_cnt=0.

## Timing
- imem_addr changes one cycle after the PC update condition. The ROM answers in the same cycle.
- ifid_* is registered: the instruction at address A appears on ifid_* one cycle after imem_addr=A.
- Redirect latency:
  - pc_sel asserted in cycle N.
  - imem_addr=target in N+1.
  - ifid carries a bubble in N+1.
  - ifid carries the target instruction in N+2.
- Flushing the in-flight ID instruction downstream of IF/ID is not done here; the ID/EX flush belongs to the hazard unit.
- Stall: while stall=1 and pc_sel=0, imem_addr and all ifid_* are constant. Fetch resumes on the first cycle with stall=0.
- Reset mid-operation: the reset values above appear in the cycle after reset is sampled high, regardless of stall, pc_sel or state. A pending redirect is discarded.
- pc_sel and reset asserted together: reset wins.

## Structure
Shared package fetch_pkg holds:
- NOP_INSTR constant (32'h00000013)
- fetch_state_t enum {RUN, HALT}
- PC_INC constant (4)

Natural sub-module: ifid_reg, the IF/ID pipeline register with load/hold/flush controls. The PC, FSM and counter stay in instr_fetch.

## Test plan
- Reset, then free-run 4 cycles with ROM word = address: imem_addr 0,4,8,12; ifid_valid 0 then 1; ifid_instr 0,4,8; fetch_cnt=3.
- stall=1 for 2 cycles at PC=8: imem_addr stays 8, ifid_pc stays 4. Release: next ifid_pc=8.
- pc_sel=1, br_pc=0x40, with stall=1 in the same cycle: next imem_addr=0x40, ifid_valid=0/NOP; following cycle ifid_pc=0x40, valid=1.
- PC=0x1FC (PC_W=9), no stall: next PC wraps to 0x000.
- pc_sel=1, br_pc=0x42: fault=1 next cycle; PC holds; ifid_valid=0 thereafter; fetch_cnt frozen. Then reset: fault=0, PC=0. Repeat with br_pc=0x200: same response.
- reset asserted while pc_sel=1, br_pc=0x80: next cycle PC=0, ifid_valid=0, fetch_cnt=0.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared constants and types for the RV32I instruction-fetch stage.
package fetch_pkg;

   // addi x0, x0, 0 -- the canonical bubble in IF/ID
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // sequential fetch advances one 32-bit word
   localparam int PC_INC = 4;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-ROM bus: fetch stage drives the byte address, the ROM answers
// combinationally in the same cycle.
interface instr_fetch_if #(
   parameter int PC_W  = 9,
   parameter int INS_W = 32
);
   logic [PC_W-1:0]  imem_addr;
   logic [INS_W-1:0] imem_rdata;

   modport master (output imem_addr, input  imem_rdata);
   modport slave  (input  imem_addr, output imem_rdata);
endinterface

// File: rtl/instr_fetch_ifid_reg.sv
// IF/ID pipeline register with load / hold / flush controls.
// flush has priority over load; neither asserted means hold.
module ifid_reg
   import fetch_pkg::*;
#(
   parameter int PC_W  = 9,
   parameter int INS_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             flush,
   input  logic [PC_W-1:0]  pc_in,
   input  logic [INS_W-1:0] instr_in,
   output logic [PC_W-1:0]  ifid_pc,
   output logic [INS_W-1:0] ifid_instr,
   output logic             ifid_valid
);

   // capture fetched word, insert a bubble on flush, otherwise hold
   always_ff @(posedge clk) begin
      if (reset) begin
         ifid_pc    <= '0;
         ifid_instr <= INS_W'(NOP_INSTR);
         ifid_valid <= 1'b0;
      end else if (flush) begin
         ifid_pc    <= pc_in;
         ifid_instr <= INS_W'(NOP_INSTR);
         ifid_valid <= 1'b0;
      end else if (load) begin
         ifid_pc    <= pc_in;
         ifid_instr <= instr_in;
         ifid_valid <= 1'b1;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: program counter, redirect handling, sticky fault FSM and
// valid-fetch counter. The IF/ID register itself lives in ifid_reg.
module instr_fetch
   import fetch_pkg::*;
#(
   parameter int PC_W  = 9,
   parameter int INS_W = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stall,
   input  logic                  pc_sel,
   input  logic [31:0]           br_pc,
   instr_fetch_if.master         bus,
   output logic [PC_W-1:0]       ifid_pc,
   output logic [INS_W-1:0]      ifid_instr,
   output logic                  ifid_valid,
   output logic                  fault,
   output logic [31:0]           fetch_cnt
);

   fetch_state_t    state, state_nxt;
   logic [PC_W-1:0] pc, pc_nxt;
   logic            illegal;
   logic            flush;
   logic            load;

   // target must be word aligned and fall inside the ROM address space
   assign illegal = (br_pc[1:0] != 2'b00) || (br_pc[31:PC_W] != '0);

   // next-state, next-PC and IF/ID control; redirect beats stall
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      flush     = 1'b0;
      load      = 1'b0;
      case (state)
         RUN: begin
            if (pc_sel) begin
               flush = 1'b1;
               if (illegal) state_nxt = HALT;  // bad target never reaches PC
               else         pc_nxt    = br_pc[PC_W-1:0];
            end else if (!stall) begin
               load   = 1'b1;
               pc_nxt = pc + PC_W'(PC_INC);   // wraps naturally at 2^PC_W
            end
         end
         HALT: begin
            flush = 1'b1;                     // bubbles forever until reset
         end
         default: begin
            flush = 1'b1;
         end
      endcase
   end

   // state, PC and fetch counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= RUN;
         pc        <= '0;
         fetch_cnt <= '0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         if (load) fetch_cnt <= fetch_cnt + 32'd1;
      end
   end

   assign bus.imem_addr = pc;
   assign fault         = (state == HALT);

   ifid_reg #(
      .PC_W  (PC_W),
      .INS_W (INS_W)
   ) u_ifid (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .flush      (flush),
      .pc_in      (pc),
      .instr_in   (bus.imem_rdata),
      .ifid_pc    (ifid_pc),
      .ifid_instr (ifid_instr),
      .ifid_valid (ifid_valid)
   );

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a vector table of inputs with the
// expected post-edge outputs, pushed into a scoreboard queue when driven and
// popped for comparison one edge later. ROM model returns word = address.
module tb_instr_fetch;
   import fetch_pkg::*;

   localparam int PC_W  = 9;
   localparam int INS_W = 32;

   logic             clk = 1'b0;
   logic             reset, stall, pc_sel;
   logic [31:0]      br_pc;
   logic [PC_W-1:0]  ifid_pc;
   logic [INS_W-1:0] ifid_instr;
   logic             ifid_valid, fault;
   logic [31:0]      fetch_cnt;

   instr_fetch_if #(.PC_W(PC_W), .INS_W(INS_W)) bus ();

   assign bus.imem_rdata = INS_W'(bus.imem_addr);

   instr_fetch #(.PC_W(PC_W), .INS_W(INS_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .pc_sel     (pc_sel),
      .br_pc      (br_pc),
      .bus        (bus.master),
      .ifid_pc    (ifid_pc),
      .ifid_instr (ifid_instr),
      .ifid_valid (ifid_valid),
      .fault      (fault),
      .fetch_cnt  (fetch_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst, stl, sel;
      logic [31:0] br;
      logic [8:0]  addr, ipc;
      logic [31:0] ins;
      logic        v, f;
      logic [31:0] cnt;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   function automatic vec_t mk(logic rst, logic stl, logic sel, logic [31:0] br,
                               logic [8:0] addr, logic [8:0] ipc, logic [31:0] ins,
                               logic v, logic f, logic [31:0] cnt);
      vec_t t;
      t.rst = rst; t.stl = stl; t.sel = sel; t.br = br;
      t.addr = addr; t.ipc = ipc; t.ins = ins; t.v = v; t.f = f; t.cnt = cnt;
      return t;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp, int row);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL row%0d %s: got %h expected %h", row, name, act, exp);
   endtask

   // drive one vector, record its expectation, compare after the edge
   task automatic step(vec_t t, int row);
      vec_t e;
      reset  = t.rst;
      stall  = t.stl;
      pc_sel = t.sel;
      br_pc  = t.br;
      sb.push_back(t);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("imem_addr",  32'(bus.imem_addr), 32'(e.addr), row);
      chk("ifid_pc",    32'(ifid_pc),       32'(e.ipc),  row);
      chk("ifid_instr", ifid_instr,         e.ins,       row);
      chk("ifid_valid", 32'(ifid_valid),    32'(e.v),    row);
      chk("fault",      32'(fault),         32'(e.f),    row);
      chk("fetch_cnt",  fetch_cnt,          e.cnt,       row);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] nop;
      nop = NOP_INSTR;
      reset = 1'b1; stall = 1'b0; pc_sel = 1'b0; br_pc = '0;

      //           rst stl sel br        addr    ipc     ins       v  f  cnt
      tbl.push_back(mk(1, 0, 0, 32'h0,   9'h000, 9'h000, nop,      0, 0, 0)); // reset
      tbl.push_back(mk(0, 0, 0, 32'h0,   9'h004, 9'h000, 32'h0,    1, 0, 1));
      tbl.push_back(mk(0, 0, 0, 32'h0,   9'h008, 9'h004, 32'h4,    1, 0, 2));
      tbl.push_back(mk(0, 1, 0, 32'h0,   9'h008, 9'h004, 32'h4,    1, 0, 2)); // stall
      tbl.push_back(mk(0, 1, 0, 32'h0,   9'h008, 9'h004, 32'h4,    1, 0, 2));
      tbl.push_back(mk(0, 0, 0, 32'h0,   9'h00C, 9'h008, 32'h8,    1, 0, 3)); // release
      tbl.push_back(mk(0, 0, 0, 32'h0,   9'h010, 9'h00C, 32'hC,    1, 0, 4));
      tbl.push_back(mk(0, 1, 1, 32'h40,  9'h040, 9'h010, nop,      0, 0, 4)); // redirect+stall
      tbl.push_back(mk(0, 0, 0, 32'h0,   9'h044, 9'h040, 32'h40,   1, 0, 5));
      tbl.push_back(mk(0, 0, 1, 32'h1F8, 9'h1F8, 9'h044, nop,      0, 0, 5)); // near top
      tbl.push_back(mk(0, 0, 0, 32'h0,   9'h1FC, 9'h1F8, 32'h1F8,  1, 0, 6));
      tbl.push_back(mk(0, 0, 0, 32'h0,   9'h000, 9'h1FC, 32'h1FC,  1, 0, 7)); // wrap
      tbl.push_back(mk(0, 0, 0, 32'h0,   9'h004, 9'h000, 32'h0,    1, 0, 8));
      tbl.push_back(mk(0, 0, 1, 32'h42,  9'h004, 9'h004, nop,      0, 1, 8)); // misaligned
      tbl.push_back(mk(0, 0, 0, 32'h0,   9'h004, 9'h004, nop,      0, 1, 8));
      tbl.push_back(mk(0, 0, 1, 32'h40,  9'h004, 9'h004, nop,      0, 1, 8)); // legal ignored
      tbl.push_back(mk(1, 0, 0, 32'h0,   9'h000, 9'h000, nop,      0, 0, 0)); // reset clears
      tbl.push_back(mk(0, 0, 0, 32'h0,   9'h004, 9'h000, 32'h0,    1, 0, 1));
      tbl.push_back(mk(0, 0, 0, 32'h0,   9'h008, 9'h004, 32'h4,    1, 0, 2));
      tbl.push_back(mk(0, 0, 1, 32'h200, 9'h008, 9'h008, nop,      0, 1, 2)); // out of ROM
      tbl.push_back(mk(0, 1, 0, 32'h0,   9'h008, 9'h008, nop,      0, 1, 2));
      tbl.push_back(mk(1, 0, 1, 32'h80,  9'h000, 9'h000, nop,      0, 0, 0)); // reset wins
      tbl.push_back(mk(0, 0, 0, 32'h0,   9'h004, 9'h000, 32'h0,    1, 0, 1));
      tbl.push_back(mk(1, 0, 1, 32'h80,  9'h000, 9'h000, nop,      0, 0, 0)); // reset in RUN
      tbl.push_back(mk(0, 0, 0, 32'h0,   9'h004, 9'h000, 32'h0,    1, 0, 1));

      for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

      // hand sequence: long stall followed by resume from PC=4
      for (int i = 0; i < 5; i++)
         step(mk(0, 1, 0, 32'h0, 9'h004, 9'h000, 32'h0, 1, 0, 1), 100 + i);
      step(mk(0, 0, 0, 32'h0, 9'h008, 9'h004, 32'h4, 1, 0, 2), 105);

      // hand sequence: fault on low-bit misalignment stays sticky for many cycles
      step(mk(0, 0, 1, 32'h3, 9'h008, 9'h008, nop, 0, 1, 2), 110);
      for (int i = 0; i < 4; i++)
         step(mk(0, i[0], i[1], 32'h10, 9'h008, 9'h008, nop, 0, 1, 2), 111 + i);
      step(mk(1, 1, 0, 32'h0, 9'h000, 9'h000, nop, 0, 0, 0), 115);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
